d_in_debounce: RTL

- Front-end conditioning stage that sits directly upstream of the D latch and drives its D_IN from a raw, asynchronous, bouncy source (switch or pin).
- Synchronises the source into the clk domain and filters glitches.
- Presents a clean level D_OUT that changes only after the input has been stable for a programmable number of cycles.
- Also outputs a BUSY flag while a candidate transition is being qualified.

---
 rtl/d_in_pkg.sv | 16 +
 rtl/d_in_debounce_sync_chain.sv | 25 ++
 rtl/d_in_debounce.sv | 130 +++++++++++++
 3 files changed

// File: rtl/d_in_pkg.sv
// Shared encodings and default parameters for the d_in_debounce front end.
package d_in_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_CHK_HI    = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_CHK_LO    = 2'd3
    } state_t;

    localparam int   DEF_SYNC_STAGES   = 2;
    localparam int   DEF_STABLE_CYCLES = 8;
    localparam int   DEF_CNT_W         = 16;
    localparam logic DEF_RESET_VAL     = 1'b0;

endpackage

// File: rtl/d_in_debounce_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: flops with async reset use <= so every stage samples the old value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/d_in_debounce.sv
// Synchronise-and-debounce stage driving the D latch input; edge pulses on RISE/FALL
// are generated only when DEBOUNCE_EDGE_PULSE_EN is defined, otherwise tied low.
module d_in_debounce
    import d_in_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter logic RESET_VAL     = DEF_RESET_VAL
) (
    input  logic clk,
    input  logic rst,
    input  logic D_RAW,
    output logic D_OUT,
    output logic BUSY,
    output logic RISE,
    output logic FALL
);

    localparam logic [CNT_W-1:0] CNT_LIM   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam state_t           ST_RESET  = RESET_VAL ? ST_STABLE_HI : ST_STABLE_LO;

    logic             s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dout_q;
    logic             busy_q;
    logic             accept_hi;
    logic             accept_lo;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (D_RAW),
        .q_o   (s)
    );

    // A level is accepted on the cycle a CHK state sees its final matching sample.
    assign accept_hi = (state_q == ST_CHK_HI) && s  && (cnt_q == CNT_LIM);
    assign accept_lo = (state_q == ST_CHK_LO) && !s && (cnt_q == CNT_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_STABLE_LO: begin
                    if (s) begin
                        state_q <= ST_CHK_HI;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CHK_HI: begin
                    if (!s) begin
                        state_q <= ST_STABLE_LO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (accept_hi) begin
                        state_q <= ST_STABLE_HI;
                        cnt_q   <= '0;
                        dout_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE_HI: begin
                    if (!s) begin
                        state_q <= ST_CHK_LO;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CHK_LO: begin
                    if (s) begin
                        state_q <= ST_STABLE_HI;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (accept_lo) begin
                        state_q <= ST_STABLE_LO;
                        cnt_q   <= '0;
                        dout_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_RESET;
                    cnt_q   <= '0;
                    dout_q  <= RESET_VAL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign D_OUT = dout_q;
    assign BUSY  = busy_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept_hi;
            fall_q <= accept_lo;
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif

endmodule
